// File: rtl/tmds_pll_supervisor.sv
// TMDS clock PLL sequencer: pulses PLL reset, filters lock, then releases the
// serializer reset ahead of the pixel reset; retries on timeout, restarts on lock loss.
module tmds_pll_supervisor #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned LOCK_FILTER    = 1024,
    parameter int unsigned SER_RST_DELAY  = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       ser_rst_n,
    output logic       pix_rst_n,
    output logic       clk_ok,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam logic [15:0] RST_LAST  = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] FILT_LAST = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] SER_LAST  = 16'(SER_RST_DELAY - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_FILTER,
        S_REL_SER,
        S_RUN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] r_tmo;
    logic        r_sync1;
    logic        r_lock_s;
    logic        r_pll_reset;
    logic        r_ser_rst_n;
    logic        r_pix_rst_n;
    logic [7:0]  r_retry_cnt;
    logic [7:0]  r_loss_cnt;
    logic        w_retry_inc;
    logic        w_loss_inc;
    logic        w_tmo_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_lock;
            r_lock_s <= r_sync1;
        end
    end

    // Timeout is checked first so the lock window can never overrun tmo.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_loss_inc  = 1'b0;
        w_tmo_hit   = (r_tmo >= TMO_LAST);
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt >= RST_LAST) w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (w_tmo_hit) begin
                    w_state_nxt = S_PLL_RST;
                    w_retry_inc = 1'b1;
                end else if (r_lock_s) begin
                    w_state_nxt = S_FILTER;
                end
            end
            S_FILTER: begin
                if (w_tmo_hit) begin
                    w_state_nxt = S_PLL_RST;
                    w_retry_inc = 1'b1;
                end else if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_cnt >= FILT_LAST) begin
                    w_state_nxt = S_REL_SER;
                end
            end
            S_REL_SER: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_retry_inc = 1'b1;
                end else if (r_cnt >= SER_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_loss_inc  = 1'b1;
                end
            end
            default: w_state_nxt = S_PLL_RST;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_pll_reset <= 1'b1;
            r_ser_rst_n <= 1'b0;
            r_pix_rst_n <= 1'b0;
            r_retry_cnt <= '0;
            r_loss_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (r_state inside {S_PLL_RST, S_FILTER, S_REL_SER})
                r_cnt <= r_cnt + 16'd1;

            // tmo spans the whole WAIT_LOCK/FILTER attempt, so only a fresh PLL reset clears it.
            if (r_state == S_PLL_RST && w_state_nxt == S_WAIT_LOCK)
                r_tmo <= '0;
            else if (r_state inside {S_WAIT_LOCK, S_FILTER})
                r_tmo <= r_tmo + 16'd1;

            r_pll_reset <= (w_state_nxt == S_PLL_RST);
            r_ser_rst_n <= (w_state_nxt == S_REL_SER) || (w_state_nxt == S_RUN);
            r_pix_rst_n <= (w_state_nxt == S_RUN);

            if (w_retry_inc && r_retry_cnt != 8'hFF) r_retry_cnt <= r_retry_cnt + 8'd1;
            if (w_loss_inc && r_loss_cnt != 8'hFF)   r_loss_cnt  <= r_loss_cnt + 8'd1;
        end
    end

    assign pll_reset = r_pll_reset;
    assign ser_rst_n = r_ser_rst_n;
    assign pix_rst_n = r_pix_rst_n;
    assign clk_ok    = r_pix_rst_n;
    assign retry_cnt = r_retry_cnt;
    assign loss_cnt  = r_loss_cnt;

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// Bench for tmds_pll_supervisor: countdown-timer reference model checked every
// cycle, plus directed sequences with hand-computed timing and counter values.
module tb_tmds_pll_supervisor;

    localparam int PRC = 4;
    localparam int LTO = 100;
    localparam int LF  = 8;
    localparam int SRD = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, ser_rst_n, pix_rst_n, clk_ok;
    logic [7:0] retry_cnt, loss_cnt;

    tmds_pll_supervisor #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .LOCK_FILTER   (LF),
        .SER_RST_DELAY (SRD)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .ser_rst_n(ser_rst_n),
        .pix_rst_n(pix_rst_n),
        .clk_ok   (clk_ok),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: phases with countdown timers; outputs follow from the phase.
    localparam int PH_RESET = 0, PH_WAIT = 1, PH_FILT = 2, PH_REL = 3, PH_RUN = 4;
    int m_ph = PH_RESET;
    int m_rst_left = PRC, m_tmo_left = 0, m_filt_left = 0, m_rel_left = 0;
    int m_retry = 0, m_loss = 0;
    bit m_s1 = 1'b0, m_ls = 1'b0;

    task automatic m_restart();
        m_ph = PH_RESET;
        m_rst_left = PRC;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_restart();
                m_retry = 0;
                m_loss  = 0;
                m_s1    = 1'b0;
                m_ls    = 1'b0;
            end else begin
                case (m_ph)
                    PH_RESET: begin
                        m_rst_left--;
                        if (m_rst_left == 0) begin
                            m_ph = PH_WAIT;
                            m_tmo_left = LTO;
                        end
                    end
                    PH_WAIT: begin
                        m_tmo_left--;
                        if (m_tmo_left == 0) begin
                            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                            m_restart();
                        end else if (m_ls) begin
                            m_ph = PH_FILT;
                            m_filt_left = LF;
                        end
                    end
                    PH_FILT: begin
                        m_tmo_left--;
                        if (m_tmo_left == 0) begin
                            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                            m_restart();
                        end else if (!m_ls) begin
                            m_ph = PH_WAIT;
                        end else begin
                            m_filt_left--;
                            if (m_filt_left == 0) begin
                                m_ph = PH_REL;
                                m_rel_left = SRD;
                            end
                        end
                    end
                    PH_REL: begin
                        if (!m_ls) begin
                            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                            m_restart();
                        end else begin
                            m_rel_left--;
                            if (m_rel_left == 0) m_ph = PH_RUN;
                        end
                    end
                    default: begin
                        if (!m_ls) begin
                            m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                            m_restart();
                        end
                    end
                endcase
                m_ls = m_s1;
                m_s1 = pll_lock;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("pll_reset", pll_reset, m_ph == PH_RESET);
                chk("ser_rst_n", ser_rst_n, m_ph == PH_REL || m_ph == PH_RUN);
                chk("pix_rst_n", pix_rst_n, m_ph == PH_RUN);
                chk("clk_ok",    clk_ok,    m_ph == PH_RUN);
                chk("retry_cnt", retry_cnt, m_retry);
                chk("loss_cnt",  loss_cnt,  m_loss);
            end
        end
    end

    function automatic bit sig(input int sel);
        case (sel)
            0:       return ser_rst_n;
            1:       return pix_rst_n;
            default: return clk_ok;
        endcase
    endfunction

    // Counts negedges until the selected output is high; an expired bound is a failure.
    task automatic wait_hi(input int sel, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(sel) && n < limit);
        if (!sig(sel)) chk($sformatf("wait_hi sel%0d timeout", sel), sig(sel), 1);
    endtask

    initial begin
        int n;
        bit lvl;
        int len;

        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst pll_reset", pll_reset, 1);
        chk("rst ser_rst_n", ser_rst_n, 0);
        chk("rst pix_rst_n", pix_rst_n, 0);
        chk("rst clk_ok",    clk_ok,    0);
        chk("rst retry_cnt", retry_cnt, 0);
        chk("rst loss_cnt",  loss_cnt,  0);

        // Clean start
        @(posedge clk);
        #1 resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pll_reset) n++;
            else break;
        end
        chk("clean pll_reset cycles", n, PRC);
        repeat (5) @(negedge clk);
        pll_lock = 1'b1;
        wait_hi(0, 40, n);
        chk("clean lock->ser edges", n, 11);
        wait_hi(1, 40, n);
        chk("clean ser->pix edges", n, SRD);
        chk("clean clk_ok", clk_ok, 1);
        chk("clean retry_cnt", retry_cnt, 0);
        chk("clean loss_cnt", loss_cnt, 0);

        // One-cycle lock loss in RUN
        repeat (2) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        @(negedge clk);
        chk("runloss clk_ok +2", clk_ok, 1);
        @(negedge clk);
        chk("runloss clk_ok +3", clk_ok, 0);
        chk("runloss pix +3", pix_rst_n, 0);
        chk("runloss ser +3", ser_rst_n, 0);
        chk("runloss pll_reset +3", pll_reset, 1);
        chk("runloss loss_cnt", loss_cnt, 1);
        chk("runloss retry_cnt", retry_cnt, 0);
        wait_hi(0, 40, n);
        chk("runloss reseq ser edges", n, 13);
        wait_hi(1, 40, n);
        chk("runloss reseq pix edges", n, SRD);

        // Async reset between edges while in RUN
        @(posedge clk);
        #2 resetn = 1'b0;
        pll_lock = 1'b0;
        #1;
        chk("async pll_reset", pll_reset, 1);
        chk("async ser_rst_n", ser_rst_n, 0);
        chk("async pix_rst_n", pix_rst_n, 0);
        chk("async clk_ok",    clk_ok,    0);
        chk("async loss_cnt",  loss_cnt,  0);
        chk("async retry_cnt", retry_cnt, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Glitchy lock: 5 high, 2 low, then steady
        repeat (6) @(negedge clk);
        pll_lock = 1'b1;
        repeat (5) @(negedge clk);
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        wait_hi(0, 40, n);
        chk("glitch 2nd lock->ser edges", n, 11);

        // Lock loss in REL_SER, landing on the same edge the delay would expire
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        @(negedge clk);
        chk("relloss ser +2", ser_rst_n, 1);
        chk("relloss pix +2", pix_rst_n, 0);
        @(negedge clk);
        chk("relloss pll_reset +3", pll_reset, 1);
        chk("relloss pix +3", pix_rst_n, 0);
        chk("relloss retry_cnt", retry_cnt, 1);
        chk("relloss loss_cnt", loss_cnt, 0);
        repeat (30) @(negedge clk);
        chk("relloss recovered clk_ok", clk_ok, 1);

        // Random lock activity with occasional mid-run resets
        lvl = 1'b1;
        for (int s = 0; s < 600; s++) begin
            lvl = ~lvl;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 200) : $urandom_range(1, 12);
            pll_lock = lvl;
            repeat (len) @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                #2 resetn = 1'b0;
                @(negedge clk);
                #2 resetn = 1'b1;
            end
        end

        // Timeout retries and saturation
        pll_lock = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (103) @(posedge clk);
        @(negedge clk);
        chk("tmo pll_reset before", pll_reset, 0);
        chk("tmo retry before", retry_cnt, 0);
        @(negedge clk);
        chk("tmo pll_reset at expiry", pll_reset, 1);
        chk("tmo retry at expiry", retry_cnt, 1);
        repeat (300 * (LTO + PRC)) @(negedge clk);
        chk("tmo retry saturated", retry_cnt, 255);
        chk("tmo loss_cnt", loss_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
